// File: rtl/ysyx_22050019_reg_scoreboard.sv
// Register scoreboard and single-write-port arbiter for the RV64 integer register file.
// Tracks outstanding writes, stalls decode on RAW/WAW and round-robins EXU/LSU writeback.
module ysyx_22050019_reg_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  localparam int NUM_REGS  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic                  id_rs1_en,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic                  id_rs2_en,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic                  id_rd_wen,
  input  logic                  exu_wb_valid,
  output logic                  exu_wb_ready,
  input  logic [ADDR_WIDTH-1:0] exu_wb_addr,
  input  logic [DATA_WIDTH-1:0] exu_wb_data,
  input  logic                  lsu_wb_valid,
  output logic                  lsu_wb_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_wb_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wb_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [NUM_REGS-1:0]   pending,
  output logic [ADDR_WIDTH:0]   outstanding,
  output logic [31:0]           stall_cnt,
  output logic                  wb_err
);

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  localparam logic [ADDR_WIDTH:0] OUT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  src_e                rr_last;
  logic                grant_exu;
  logic                grant_lsu;
  logic                hazard1;
  logic                hazard2;
  logic                waw;
  logic                issue;
  logic                set;
  logic                inc;
  logic                dec;
  logic [NUM_REGS-1:0] pending_nxt;

  // Grants are held off during reset so nothing reaches the register file.
  always_comb begin
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (rst_n) begin
      if (exu_wb_valid && lsu_wb_valid) begin
        if (rr_last == SRC_EXU) grant_lsu = 1'b1;
        else                    grant_exu = 1'b1;
      end else begin
        grant_exu = exu_wb_valid;
        grant_lsu = lsu_wb_valid;
      end
    end
  end

  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    if (grant_exu) begin
      rf_waddr = exu_wb_addr;
      rf_wdata = exu_wb_data;
    end else if (grant_lsu) begin
      rf_waddr = lsu_wb_addr;
      rf_wdata = lsu_wb_data;
    end
  end

  assign exu_wb_ready = grant_exu;
  assign lsu_wb_ready = grant_lsu;
  assign rf_wen       = (grant_exu || grant_lsu) && (rf_waddr != '0);

  // A writeback landing this cycle releases its hazard; the register file bypasses the data.
  assign hazard1  = id_rs1_en && (id_rs1 != '0) && pending[id_rs1] &&
                    !(rf_wen && (rf_waddr == id_rs1));
  assign hazard2  = id_rs2_en && (id_rs2 != '0) && pending[id_rs2] &&
                    !(rf_wen && (rf_waddr == id_rs2));
  assign waw      = id_rd_wen && (id_rd != '0) && pending[id_rd] &&
                    !(rf_wen && (rf_waddr == id_rd));
  assign id_ready = !(hazard1 || hazard2 || waw);

  assign issue = id_valid && id_ready;
  assign set   = issue && id_rd_wen && (id_rd != '0);

  // Set is applied after clear so a same-index set/clear leaves the bit pending.
  always_comb begin
    pending_nxt = pending;
    if (rf_wen) pending_nxt[rf_waddr] = 1'b0;
    if (set)    pending_nxt[id_rd]    = 1'b1;
  end

  assign inc = set && !pending[id_rd];
  assign dec = rf_wen && pending[rf_waddr] && !(set && (id_rd == rf_waddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      outstanding <= '0;
      stall_cnt   <= '0;
      wb_err      <= 1'b0;
      rr_last     <= SRC_EXU;
    end else begin
      pending <= pending_nxt;
      case ({inc, dec})
        2'b10:   outstanding <= outstanding + OUT_ONE;
        2'b01:   outstanding <= outstanding - OUT_ONE;
        default: outstanding <= outstanding;
      endcase
      if (id_valid && !id_ready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      // Writing a register nobody was waiting on means a unit broke the issue protocol.
      if (rf_wen && !pending[rf_waddr])
        wb_err <= 1'b1;
      if (exu_wb_valid && lsu_wb_valid)
        rr_last <= grant_lsu ? SRC_LSU : SRC_EXU;
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_reg_scoreboard.sv
// Directed bench for the register scoreboard: hazards, arbitration, clear/set races and reset.
module tb_ysyx_22050019_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1;
  logic        id_rs1_en;
  logic [4:0]  id_rs2;
  logic        id_rs2_en;
  logic [4:0]  id_rd;
  logic        id_rd_wen;
  logic        exu_wb_valid;
  logic        exu_wb_ready;
  logic [4:0]  exu_wb_addr;
  logic [63:0] exu_wb_data;
  logic        lsu_wb_valid;
  logic        lsu_wb_ready;
  logic [4:0]  lsu_wb_addr;
  logic [63:0] lsu_wb_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] pending;
  logic [5:0]  outstanding;
  logic [31:0] stall_cnt;
  logic        wb_err;

  int checks = 0;
  int passed = 0;

  ysyx_22050019_reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs1_en(id_rs1_en),
    .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen),
    .exu_wb_valid(exu_wb_valid), .exu_wb_ready(exu_wb_ready),
    .exu_wb_addr(exu_wb_addr), .exu_wb_data(exu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending), .outstanding(outstanding),
    .stall_cnt(stall_cnt), .wb_err(wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs1_en = 0; id_rs2 = 0; id_rs2_en = 0;
    id_rd = 0; id_rd_wen = 0;
    exu_wb_valid = 0; exu_wb_addr = 0; exu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_addr = 0; lsu_wb_data = 0;
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    idle();
    id_valid = 1; id_rd = rd; id_rd_wen = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1;
    #1 rst_n = 0;
    exu_wb_valid = 1; exu_wb_addr = 5; exu_wb_data = 64'h11;
    lsu_wb_valid = 1; lsu_wb_addr = 6; lsu_wb_data = 64'h22;
    #1;
    checks++; if (rf_wen !== 1'b0) $display("[TB] FAIL reset_rf_wen: got %0h expected 0", rf_wen); else passed++;
    checks++; if (exu_wb_ready !== 1'b0) $display("[TB] FAIL reset_exu_ready: got %0h expected 0", exu_wb_ready); else passed++;
    checks++; if (lsu_wb_ready !== 1'b0) $display("[TB] FAIL reset_lsu_ready: got %0h expected 0", lsu_wb_ready); else passed++;
    tick();
    checks++; if (pending !== 32'h0) $display("[TB] FAIL reset_pending: got %0h expected 0", pending); else passed++;
    checks++; if (outstanding !== 6'd0) $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding); else passed++;
    checks++; if (stall_cnt !== 32'd0) $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); else passed++;
    checks++; if (wb_err !== 1'b0) $display("[TB] FAIL reset_wb_err: got %0h expected 0", wb_err); else passed++;
    idle();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_issue();
    id_valid = 1; id_rd = 5; id_rd_wen = 1;
    #1;
    checks++; if (id_ready !== 1'b1) $display("[TB] FAIL issue_ready: got %0h expected 1", id_ready); else passed++;
    tick();
    idle();
    checks++; if (pending !== 32'h20) $display("[TB] FAIL issue_pending: got %0h expected 20", pending); else passed++;
    checks++; if (outstanding !== 6'd1) $display("[TB] FAIL issue_outstanding: got %0d expected 1", outstanding); else passed++;
  endtask

  task automatic test_raw_release();
    id_valid = 1; id_rs1 = 5; id_rs1_en = 1;
    #1;
    checks++; if (id_ready !== 1'b0) $display("[TB] FAIL raw_stall: got %0h expected 0", id_ready); else passed++;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (stall_cnt !== 32'd3) $display("[TB] FAIL raw_stall_cnt: got %0d expected 3", stall_cnt); else passed++;
    exu_wb_valid = 1; exu_wb_addr = 5; exu_wb_data = 64'hDEAD;
    #1;
    checks++; if (id_ready !== 1'b1) $display("[TB] FAIL raw_release_ready: got %0h expected 1", id_ready); else passed++;
    checks++; if (rf_wen !== 1'b1) $display("[TB] FAIL raw_rf_wen: got %0h expected 1", rf_wen); else passed++;
    checks++; if (rf_waddr !== 5'd5) $display("[TB] FAIL raw_rf_waddr: got %0d expected 5", rf_waddr); else passed++;
    checks++; if (rf_wdata !== 64'hDEAD) $display("[TB] FAIL raw_rf_wdata: got %0h expected dead", rf_wdata); else passed++;
    checks++; if (exu_wb_ready !== 1'b1) $display("[TB] FAIL raw_exu_ready: got %0h expected 1", exu_wb_ready); else passed++;
    tick();
    idle();
    checks++; if (pending !== 32'h0) $display("[TB] FAIL raw_pending: got %0h expected 0", pending); else passed++;
    checks++; if (outstanding !== 6'd0) $display("[TB] FAIL raw_outstanding: got %0d expected 0", outstanding); else passed++;
    checks++; if (stall_cnt !== 32'd3) $display("[TB] FAIL raw_stall_hold: got %0d expected 3", stall_cnt); else passed++;
    checks++; if (wb_err !== 1'b0) $display("[TB] FAIL raw_wb_err: got %0h expected 0", wb_err); else passed++;
  endtask

  task automatic test_arbitration();
    logic [4:0] regs [6];
    regs = '{5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9};
    // Back-to-back independent issues, one per cycle.
    for (int i = 0; i < 6; i++) begin
      id_valid = 1; id_rd = regs[i]; id_rd_wen = 1;
      tick();
    end
    idle();
    checks++; if (pending !== 32'h3D8) $display("[TB] FAIL arb_setup_pending: got %0h expected 3d8", pending); else passed++;
    checks++; if (outstanding !== 6'd6) $display("[TB] FAIL arb_setup_outstanding: got %0d expected 6", outstanding); else passed++;
    exu_wb_valid = 1; exu_wb_addr = 3; exu_wb_data = 64'hE3;
    lsu_wb_valid = 1; lsu_wb_addr = 4; lsu_wb_data = 64'hA4;
    #1;
    checks++; if ({exu_wb_ready, lsu_wb_ready} !== 2'b01) $display("[TB] FAIL arb_c1_grant: got %b expected 01", {exu_wb_ready, lsu_wb_ready}); else passed++;
    checks++; if (rf_wdata !== 64'hA4) $display("[TB] FAIL arb_c1_wdata: got %0h expected a4", rf_wdata); else passed++;
    tick();
    checks++; if (pending !== 32'h3C8) $display("[TB] FAIL arb_c1_pending: got %0h expected 3c8", pending); else passed++;
    lsu_wb_addr = 7; lsu_wb_data = 64'hA7;
    #1;
    checks++; if ({exu_wb_ready, lsu_wb_ready} !== 2'b10) $display("[TB] FAIL arb_c2_grant: got %b expected 10", {exu_wb_ready, lsu_wb_ready}); else passed++;
    checks++; if (rf_waddr !== 5'd3) $display("[TB] FAIL arb_c2_waddr: got %0d expected 3", rf_waddr); else passed++;
    checks++; if (rf_wdata !== 64'hE3) $display("[TB] FAIL arb_c2_wdata: got %0h expected e3", rf_wdata); else passed++;
    tick();
    checks++; if (pending !== 32'h3C0) $display("[TB] FAIL arb_c2_pending: got %0h expected 3c0", pending); else passed++;
    exu_wb_addr = 6; exu_wb_data = 64'hE6;
    #1;
    checks++; if ({exu_wb_ready, lsu_wb_ready} !== 2'b01) $display("[TB] FAIL arb_c3_grant: got %b expected 01", {exu_wb_ready, lsu_wb_ready}); else passed++;
    checks++; if (rf_waddr !== 5'd7) $display("[TB] FAIL arb_c3_waddr: got %0d expected 7", rf_waddr); else passed++;
    tick();
    idle();
    checks++; if (pending !== 32'h340) $display("[TB] FAIL arb_c3_pending: got %0h expected 340", pending); else passed++;
    checks++; if (outstanding !== 6'd3) $display("[TB] FAIL arb_c3_outstanding: got %0d expected 3", outstanding); else passed++;
  endtask

  task automatic test_set_clear_same();
    issue_rd(5'd7);
    checks++; if (outstanding !== 6'd4) $display("[TB] FAIL scs_setup_outstanding: got %0d expected 4", outstanding); else passed++;
    exu_wb_valid = 1; exu_wb_addr = 7; exu_wb_data = 64'h77;
    id_valid = 1; id_rd = 7; id_rd_wen = 1;
    #1;
    checks++; if (id_ready !== 1'b1) $display("[TB] FAIL scs_ready: got %0h expected 1", id_ready); else passed++;
    checks++; if (rf_wen !== 1'b1) $display("[TB] FAIL scs_rf_wen: got %0h expected 1", rf_wen); else passed++;
    tick();
    idle();
    checks++; if (pending !== 32'h3C0) $display("[TB] FAIL scs_pending: got %0h expected 3c0", pending); else passed++;
    checks++; if (outstanding !== 6'd4) $display("[TB] FAIL scs_outstanding: got %0d expected 4", outstanding); else passed++;
  endtask

  task automatic test_hazard_sources();
    id_rs2 = 8; id_rs2_en = 1;
    #1;
    checks++; if (id_ready !== 1'b0) $display("[TB] FAIL hz_rs2: got %0h expected 0", id_ready); else passed++;
    id_rs1 = 0; id_rs1_en = 1; id_rs2 = 0; id_rd = 0; id_rd_wen = 1;
    #1;
    checks++; if (id_ready !== 1'b1) $display("[TB] FAIL hz_x0: got %0h expected 1", id_ready); else passed++;
    idle();
    id_rd = 6; id_rd_wen = 1;
    #1;
    checks++; if (id_ready !== 1'b0) $display("[TB] FAIL hz_waw: got %0h expected 0", id_ready); else passed++;
    idle();
    id_rs2 = 8; id_rs2_en = 0; id_rs1 = 5; id_rs1_en = 1;
    #1;
    checks++; if (id_ready !== 1'b1) $display("[TB] FAIL hz_disabled_src: got %0h expected 1", id_ready); else passed++;
    idle();
    tick();
  endtask

  task automatic test_wb_x0();
    lsu_wb_valid = 1; lsu_wb_addr = 0; lsu_wb_data = 64'h1234;
    #1;
    checks++; if (rf_wen !== 1'b0) $display("[TB] FAIL x0_rf_wen: got %0h expected 0", rf_wen); else passed++;
    checks++; if (lsu_wb_ready !== 1'b1) $display("[TB] FAIL x0_ready: got %0h expected 1", lsu_wb_ready); else passed++;
    tick();
    idle();
    checks++; if (wb_err !== 1'b0) $display("[TB] FAIL x0_wb_err: got %0h expected 0", wb_err); else passed++;
    checks++; if (pending !== 32'h3C0) $display("[TB] FAIL x0_pending: got %0h expected 3c0", pending); else passed++;
  endtask

  task automatic test_wb_err();
    exu_wb_valid = 1; exu_wb_addr = 9; exu_wb_data = 64'h99;
    tick();
    idle();
    checks++; if (wb_err !== 1'b0) $display("[TB] FAIL err_legal_wb: got %0h expected 0", wb_err); else passed++;
    checks++; if (outstanding !== 6'd3) $display("[TB] FAIL err_outstanding1: got %0d expected 3", outstanding); else passed++;
    exu_wb_valid = 1; exu_wb_addr = 9; exu_wb_data = 64'h9A;
    #1;
    checks++; if (rf_wen !== 1'b1) $display("[TB] FAIL err_rf_wen: got %0h expected 1", rf_wen); else passed++;
    tick();
    idle();
    checks++; if (wb_err !== 1'b1) $display("[TB] FAIL err_set: got %0h expected 1", wb_err); else passed++;
    checks++; if (pending !== 32'h1C0) $display("[TB] FAIL err_pending: got %0h expected 1c0", pending); else passed++;
    checks++; if (outstanding !== 6'd3) $display("[TB] FAIL err_outstanding2: got %0d expected 3", outstanding); else passed++;
    tick();
    checks++; if (wb_err !== 1'b1) $display("[TB] FAIL err_sticky: got %0h expected 1", wb_err); else passed++;
  endtask

  task automatic test_async_reset();
    issue_rd(5'd9);
    checks++; if (outstanding !== 6'd4) $display("[TB] FAIL ar_setup_outstanding: got %0d expected 4", outstanding); else passed++;
    exu_wb_valid = 1; exu_wb_addr = 6; exu_wb_data = 64'h66;
    #1;
    checks++; if (rf_wen !== 1'b1) $display("[TB] FAIL ar_pre_rf_wen: got %0h expected 1", rf_wen); else passed++;
    #1 rst_n = 0;
    #1;
    checks++; if (pending !== 32'h0) $display("[TB] FAIL ar_pending: got %0h expected 0", pending); else passed++;
    checks++; if (outstanding !== 6'd0) $display("[TB] FAIL ar_outstanding: got %0d expected 0", outstanding); else passed++;
    checks++; if (stall_cnt !== 32'd0) $display("[TB] FAIL ar_stall_cnt: got %0d expected 0", stall_cnt); else passed++;
    checks++; if (wb_err !== 1'b0) $display("[TB] FAIL ar_wb_err: got %0h expected 0", wb_err); else passed++;
    checks++; if (rf_wen !== 1'b0) $display("[TB] FAIL ar_rf_wen: got %0h expected 0", rf_wen); else passed++;
    idle();
    tick();
    rst_n = 1;
    tick();
    // After reset the first contended grant must again go to the LSU.
    exu_wb_valid = 1; exu_wb_addr = 0;
    lsu_wb_valid = 1; lsu_wb_addr = 0;
    #1;
    checks++; if ({exu_wb_ready, lsu_wb_ready} !== 2'b01) $display("[TB] FAIL ar_rr_reset: got %b expected 01", {exu_wb_ready, lsu_wb_ready}); else passed++;
    tick();
    idle();
    checks++; if (outstanding !== 6'd0) $display("[TB] FAIL ar_post_outstanding: got %0d expected 0", outstanding); else passed++;
  endtask

  initial begin
    $display("[TB] starting reg_scoreboard bench");
    test_reset();
    test_issue();
    test_raw_release();
    test_arbitration();
    test_set_clear_same();
    test_hazard_sources();
    test_wb_x0();
    test_wb_err();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
